// File: rtl/mprj_cfg_serializer.sv
// Pad configuration loader: holds one CFG_BITS word per mprj_io pad and
// shifts the whole bank into the GPIO control chain, then strobes load.
// Bit order on the wire: pad IO_PADS-1 first, pad 0 last, each word MSB first.
module mprj_cfg_serializer #(
    parameter int                  IO_PADS     = 38,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                xfer_start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int N  = IO_PADS * CFG_BITS;
    localparam int PW = (IO_PADS > 1) ? $clog2(IO_PADS) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Bit counter is wide enough to hold N itself so it can never wrap.
    localparam int CW = $clog2(N + 1);
    localparam logic [6:0] PADS7 = 7'(IO_PADS);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_WAIT,
        LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [PW-1:0]       pad_q, pad_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sdo_q, sdo_d;
    logic                done_q, done_d;
    logic                rstn_q;
    logic [CFG_BITS-1:0] rdata_q;
    logic [CFG_BITS-1:0] bank_q [IO_PADS];
    logic                phase_end;
    logic                addr_ok;

    assign phase_end = (div_q == DW'(CLK_DIV - 1));
    assign addr_ok   = ({1'b0, cfg_addr} < PADS7);

    // Configuration bank: writes only while idle so the bank is frozen during a shift.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < IO_PADS; i++) bank_q[i] <= DEFAULT_CFG;
        end else if (cfg_we && addr_ok && (state_q == IDLE)) begin
            bank_q[cfg_addr[PW-1:0]] <= cfg_wdata;
        end
    end

    // Registered readback; same-cycle write is not yet visible here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) rdata_q <= '0;
        else          rdata_q <= addr_ok ? bank_q[cfg_addr[PW-1:0]] : '0;
    end

    // Sequencer state, divider, bit pointer and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            pad_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pad_q   <= pad_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            rstn_q  <= 1'b1;
        end
    end

    // Next state: each non-idle state lasts CLK_DIV cycles; data is set up on SHIFT_LO entry.
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || phase_end) ? '0 : div_q + 1'b1;
        pad_d   = pad_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    state_d = SHIFT_LO;
                    pad_d   = PW'(IO_PADS - 1);
                    bit_d   = BW'(CFG_BITS - 1);
                    cnt_d   = '0;
                    sdo_d   = bank_q[IO_PADS-1][CFG_BITS-1];
                end
            end
            SHIFT_LO: begin
                if (phase_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = LOAD_WAIT;
                    end else begin
                        state_d = SHIFT_LO;
                        cnt_d   = cnt_q + 1'b1;
                        if (bit_q == '0) begin
                            bit_d = BW'(CFG_BITS - 1);
                            pad_d = pad_q - 1'b1;
                        end else begin
                            bit_d = bit_q - 1'b1;
                        end
                        sdo_d = bank_q[pad_d][bit_d];
                    end
                end
            end
            LOAD_WAIT: begin
                if (phase_end) state_d = LOAD;
            end
            LOAD: begin
                if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_rdata       = rdata_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign serial_clock    = (state_q == SHIFT_HI);
    assign serial_data_out = sdo_q;
    assign serial_load     = (state_q == LOAD);
    assign serial_resetn   = rstn_q;

endmodule
